// File: rtl/display_pkg.sv
// Shared types and default geometry for the display manager slice.
// The frame is one full clear followed by alternating pipe passes.
package display_pkg;

   localparam int DEF_SCREEN_W   = 640;
   localparam int DEF_SCREEN_H   = 480;
   localparam int DEF_PIPE_W     = 50;
   localparam int DEF_PASS_LIMIT = 1023;
   localparam int COORD_W        = 11;
   localparam int CNT_W          = 10;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_PIPE1 = 2'd1,
      ST_PIPE2 = 2'd2
   } state_t;

   // A pipe starting below the visible area still draws the bottom row.
   function automatic logic [COORD_W-1:0] clamp_row(input logic [COORD_W-1:0] row_in,
                                                    input int screen_h);
      if (row_in >= COORD_W'(screen_h)) begin
         return COORD_W'(screen_h - 1);
      end else begin
         return row_in;
      end
   endfunction

endpackage

// File: rtl/clear_screen.sv
// Row-major full-screen scanner used to erase the frame, one pixel per
// enabled cycle; parks at (0,0) whenever disabled.
module clear_screen
   import display_pkg::*;
#(
   parameter int SCREEN_W = DEF_SCREEN_W,
   parameter int SCREEN_H = DEF_SCREEN_H
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   output logic               done,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y
);

   logic [COORD_W-1:0] x_r;
   logic [COORD_W-1:0] y_r;
   logic               last_col_s;

   assign last_col_s = (x_r == COORD_W'(SCREEN_W - 1));
   assign done       = enable && last_col_s && (y_r == COORD_W'(SCREEN_H - 1));
   assign x          = x_r;
   assign y          = y_r;

   // Scan position: held at origin while idle, wraps to origin after the last pixel.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x_r <= '0;
         y_r <= '0;
      end else if (!enable || done) begin
         x_r <= '0;
         y_r <= '0;
      end else if (last_col_s) begin
         x_r <= '0;
         y_r <= y_r + COORD_W'(1);
      end else begin
         x_r <= x_r + COORD_W'(1);
         y_r <= y_r;
      end
   end

endmodule

// File: rtl/pipe_drawer.sv
// Draws one pipe: PIPE_W columns from pipe_x, rows from pipe_y to the bottom.
// Position is kept as offsets so live pipe_x/pipe_y changes apply at once.
module pipe_drawer
   import display_pkg::*;
#(
   parameter int SCREEN_H = DEF_SCREEN_H,
   parameter int PIPE_W   = DEF_PIPE_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   output logic               done,
   input  logic [COORD_W-1:0] pipe_x,
   input  logic [COORD_W-1:0] pipe_y,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y
);

   logic [COORD_W-1:0] col_r;
   logic [COORD_W-1:0] row_r;
   logic [COORD_W-1:0] origin_y_s;
   logic [COORD_W:0]   row_sum_s;
   logic               last_col_s;
   logic               last_row_s;

   assign origin_y_s = clamp_row(pipe_y, SCREEN_H);
   assign row_sum_s  = {1'b0, origin_y_s} + {1'b0, row_r};
   assign last_col_s = (col_r == COORD_W'(PIPE_W - 1));
   assign last_row_s = (row_sum_s >= (COORD_W + 1)'(SCREEN_H - 1));
   assign done       = enable && last_col_s && last_row_s;
   // Column wraps modulo 2048; there is deliberately no horizontal clipping.
   assign x          = pipe_x + col_r;
   assign y          = row_sum_s[COORD_W-1:0];

   // Offset counters: held at origin while idle, back to origin after done.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col_r <= '0;
         row_r <= '0;
      end else if (!enable || done) begin
         col_r <= '0;
         row_r <= '0;
      end else if (last_col_s) begin
         col_r <= '0;
         row_r <= row_r + COORD_W'(1);
      end else begin
         col_r <= col_r + COORD_W'(1);
         row_r <= row_r;
      end
   end

endmodule

// File: rtl/display_manager.sv
// Frame sequencer: one full clear, then PIPE1/PIPE2 passes until the
// saturating pass counter reaches PASS_LIMIT, then the next clear.
module display_manager
   import display_pkg::*;
#(
   parameter int SCREEN_W   = DEF_SCREEN_W,
   parameter int SCREEN_H   = DEF_SCREEN_H,
   parameter int PIPE_W     = DEF_PIPE_W,
   parameter int PASS_LIMIT = DEF_PASS_LIMIT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [COORD_W-1:0] pipe1_x,
   input  logic [COORD_W-1:0] pipe1_y,
   input  logic [COORD_W-1:0] pipe2_x,
   input  logic [COORD_W-1:0] pipe2_y,
   input  logic [COORD_W-1:0] bird_x,
   input  logic [COORD_W-1:0] bird_y,
   output logic               color,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y
);

   state_t             state_r;
   state_t             state_nx_s;
   logic [CNT_W-1:0]   pass_cnt_r;
   logic               clr_done_s;
   logic               p1_done_s;
   logic               p2_done_s;
   logic               pipe_done_s;
   logic               cnt_full_s;
   logic [COORD_W-1:0] clr_x_s, clr_y_s;
   logic [COORD_W-1:0] p1_x_s, p1_y_s;
   logic [COORD_W-1:0] p2_x_s, p2_y_s;
   logic               bird_unused_s;

   // The bird is drawn elsewhere; its coordinates are accepted but not used.
   assign bird_unused_s = ^{bird_x, bird_y};

   assign pipe_done_s = p1_done_s || p2_done_s;
   assign cnt_full_s  = (pass_cnt_r == CNT_W'(PASS_LIMIT));

   clear_screen #(.SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)) u_clear (
      .clk(clk), .reset(reset), .enable(state_r == ST_CLEAR),
      .done(clr_done_s), .x(clr_x_s), .y(clr_y_s)
   );

   pipe_drawer #(.SCREEN_H(SCREEN_H), .PIPE_W(PIPE_W)) u_pipe1 (
      .clk(clk), .reset(reset), .enable(state_r == ST_PIPE1), .done(p1_done_s),
      .pipe_x(pipe1_x), .pipe_y(pipe1_y), .x(p1_x_s), .y(p1_y_s)
   );

   pipe_drawer #(.SCREEN_H(SCREEN_H), .PIPE_W(PIPE_W)) u_pipe2 (
      .clk(clk), .reset(reset), .enable(state_r == ST_PIPE2), .done(p2_done_s),
      .pipe_x(pipe2_x), .pipe_y(pipe2_y), .x(p2_x_s), .y(p2_y_s)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_CLEAR;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state: advance on the active drawer's done; limit check uses the pre-increment count.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_CLEAR: begin
            if (clr_done_s) state_nx_s = ST_PIPE1;
            else            state_nx_s = ST_CLEAR;
         end
         ST_PIPE1: begin
            if (p1_done_s) state_nx_s = ST_PIPE2;
            else           state_nx_s = ST_PIPE1;
         end
         ST_PIPE2: begin
            if (p2_done_s && cnt_full_s) state_nx_s = ST_CLEAR;
            else if (p2_done_s)          state_nx_s = ST_PIPE1;
            else                         state_nx_s = ST_PIPE2;
         end
         default: state_nx_s = ST_CLEAR;
      endcase
   end

   // Saturating pass counter, zeroed throughout the clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pass_cnt_r <= '0;
      end else if (state_r == ST_CLEAR) begin
         pass_cnt_r <= '0;
      end else if (pipe_done_s && !cnt_full_s) begin
         pass_cnt_r <= pass_cnt_r + CNT_W'(1);
      end else begin
         pass_cnt_r <= pass_cnt_r;
      end
   end

   // Pixel output follows the drawer owned by the current state.
   always_comb begin
      x     = '0;
      y     = '0;
      color = 1'b0;
      case (state_r)
         ST_CLEAR: begin
            x     = clr_x_s;
            y     = clr_y_s;
            color = 1'b0;
         end
         ST_PIPE1: begin
            x     = p1_x_s;
            y     = p1_y_s;
            color = 1'b1;
         end
         ST_PIPE2: begin
            x     = p2_x_s;
            y     = p2_y_s;
            color = 1'b1;
         end
         default: begin
            x     = '0;
            y     = '0;
            color = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_display_manager.sv
// Randomized bench for display_manager on a reduced screen, checked each
// cycle against a frame-level pixel-sequence model.
module tb_display_manager;

   localparam int W   = 32;
   localparam int H   = 24;
   localparam int PW  = 6;
   localparam int LIM = 9;

   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] p1x, p1y, p2x, p2y, bx, by;
   logic        color;
   logic [10:0] x, y;

   int total = 0;
   int bad   = 0;

   // model: phase 0 = clear, 1 = pipe1, 2 = pipe2
   int ph, cx, cy, c, r, cnt;
   bit ch1, ch2, rst_done;

   display_manager #(.SCREEN_W(W), .SCREEN_H(H), .PIPE_W(PW), .PASS_LIMIT(LIM)) dut (
      .clk(clk), .reset(reset),
      .pipe1_x(p1x), .pipe1_y(p1y), .pipe2_x(p2x), .pipe2_y(p2y),
      .bird_x(bx), .bird_y(by),
      .color(color), .x(x), .y(y)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      ph = 0; cx = 0; cy = 0; c = 0; r = 0; cnt = 0;
      ch1 = 1'b0; ch2 = 1'b0;
   endtask

   task automatic model_expect(output int ex, output int ey, output int ec, output bit ed);
      int px, py;
      if (ph == 0) begin
         ex = cx; ey = cy; ec = 0;
         ed = (cx == W - 1) && (cy == H - 1);
      end else begin
         px = (ph == 1) ? int'(p1x) : int'(p2x);
         py = (ph == 1) ? int'(p1y) : int'(p2y);
         if (py >= H) py = H - 1;
         ex = (px + c) % 2048;
         ey = py + r;
         ec = 1;
         ed = (c == PW - 1) && (ey == H - 1);
      end
   endtask

   task automatic model_advance(input bit ed);
      int old;
      if (ph == 0) begin
         cnt = 0;
         if (ed) begin
            cx = 0; cy = 0; ph = 1; ch2 = 1'b1;
         end else if (cx == W - 1) begin
            cx = 0; cy++;
         end else begin
            cx++;
         end
      end else if (ed) begin
         old = cnt;
         if (cnt < LIM) cnt++;
         c = 0; r = 0;
         if (ph == 1) begin
            ph = 2; ch1 = 1'b1;
         end else if (old == LIM) begin
            ph = 0;
         end else begin
            ph = 1; ch2 = 1'b1;
         end
      end else if (c == PW - 1) begin
         c = 0; r++;
      end else begin
         c++;
      end
   endtask

   task automatic rand_pipe(output logic [10:0] px, output logic [10:0] py);
      if ($urandom_range(0, 3) == 0) px = 11'(2047 - $urandom_range(0, PW));
      else                           px = 11'($urandom_range(0, 2047));
      py = 11'($urandom_range(0, H + 8));
   endtask

   // Called at a falling edge: compare, step the model, then update idle pipe inputs.
   task automatic cycle();
      int ex, ey, ec;
      bit ed;
      model_expect(ex, ey, ec, ed);
      chk("x", {21'd0, x}, ex);
      chk("y", {21'd0, y}, ey);
      chk("color", {31'd0, color}, ec);
      model_advance(ed);
      @(posedge clk);
      #1;
      if (ch1) begin rand_pipe(p1x, p1y); ch1 = 1'b0; end
      if (ch2) begin rand_pipe(p2x, p2y); ch2 = 1'b0; end
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b0;
      p1x = 11'd10;   p1y = 11'd15;
      p2x = 11'd2044; p2y = 11'd40;
      bx = 11'd123;   by = 11'd456;
      rst_done = 1'b0;
      #1;
      chk("rst_x", {21'd0, x}, 32'd0);
      chk("rst_y", {21'd0, y}, 32'd0);
      chk("rst_color", {31'd0, color}, 32'd0);
      repeat (3) @(negedge clk);
      chk("rst_hold_x", {21'd0, x}, 32'd0);
      reset = 1'b1;
      model_reset();

      for (int i = 0; i < 7000; i++) begin
         if (!rst_done && i > 2500 && ph == 1 && c == 3) begin
            #2 reset = 1'b0;
            #1;
            chk("mid_rst_x", {21'd0, x}, 32'd0);
            chk("mid_rst_y", {21'd0, y}, 32'd0);
            chk("mid_rst_color", {31'd0, color}, 32'd0);
            @(posedge clk);
            #1;
            chk("mid_rst_hold_x", {21'd0, x}, 32'd0);
            chk("mid_rst_hold_color", {31'd0, color}, 32'd0);
            @(negedge clk);
            reset = 1'b1;
            model_reset();
            rst_done = 1'b1;
         end
         bx = 11'($urandom_range(0, 2047));
         by = 11'($urandom_range(0, 2047));
         cycle();
         if (bad > 50) break;
      end

      chk("mid_rst_seen", {31'd0, rst_done}, 32'd1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/display_manager.md
DISPLAY_MANAGER -- requirements
Module: display_manager

Interface
REQ-001 Parameter SCREEN_W, default 640, visible columns.
REQ-002 Parameter SCREEN_H, default 480, visible rows.
REQ-003 Parameter PIPE_W, default 50, pipe width in pixels.
REQ-004 Parameter PASS_LIMIT, default 1023, saturating draw-pass count that triggers a screen clear.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 pipe1_x, pipe1_y  input  11 each  left column / top row of pipe 1.
REQ-008 pipe2_x, pipe2_y  input  11 each  left column / top row of pipe 2.
REQ-009 bird_x, bird_y  input  11 each  reserved; SHALL be ignored.
REQ-010 color  output  1  1 = draw pixel, 0 = erase pixel.
REQ-011 x, y  output  11 each  current pixel coordinate, one pixel per cycle.

Function
REQ-012 Top FSM states SHALL be CLEAR, PIPE1, PIPE2; a BIRD state SHALL NOT be implemented.
REQ-013 CLEAR: on clear_done go to PIPE1, else stay.
REQ-014 PIPE1: on pipe1 done go to PIPE2, else stay.
REQ-015 PIPE2: on pipe2 done with pass counter == PASS_LIMIT go to CLEAR; on done otherwise go to PIPE1; else stay.
REQ-016 The 10-bit pass counter SHALL clear to 0 every cycle in CLEAR and otherwise increment by 1 on any cycle a pipe done is high, saturating at PASS_LIMIT.
REQ-017 Each drawer SHALL run only while enabled: clear drawer enabled iff state == CLEAR; pipe drawer N enabled iff state == PIPEN.
REQ-018 x/y SHALL combinationally follow the drawer of the current state.
REQ-019 color SHALL equal 1 in PIPE1/PIPE2 and 0 in CLEAR.
REQ-020 Clear drawer SHALL scan row-major, x fastest: (0,0),(1,0)..(639,0),(0,1)..(639,479), one coordinate per enabled cycle.
REQ-021 Clear done SHALL be high combinationally during the cycle the coordinate (SCREEN_W-1, SCREEN_H-1) is output; the scan SHALL then return to (0,0).
REQ-022 Pipe drawer SHALL scan row-major columns pipe_x..pipe_x+PIPE_W-1 over rows pipe_y..SCREEN_H-1, one coordinate per enabled cycle.
REQ-023 Pipe done SHALL be high during the cycle (pipe_x+PIPE_W-1, SCREEN_H-1) is output; the scan SHALL then return to origin.
REQ-024 pipe_y >= SCREEN_H SHALL be treated as SCREEN_H-1 (one row drawn).
REQ-025 Column arithmetic SHALL be 11-bit modulo 2048; no horizontal clipping.
REQ-026 While a drawer is disabled its scan SHALL be held at origin, so every enable starts from the first coordinate.
REQ-027 pipe_x/pipe_y SHALL be sampled by the drawer every cycle; mid-scan changes take effect immediately.
REQ-028 Frame sequence SHALL repeat: one full clear, then PIPE1/PIPE2 alternation until the saturated counter triggers the next clear.

Reset
REQ-029 Asserting reset (low) SHALL asynchronously force state CLEAR, pass counter 0, and every drawer scan to origin.
REQ-030 During and immediately after reset, outputs SHALL be x=0, y=0, color=0.
REQ-031 Reset asserted mid-draw SHALL abandon the drawing with no done pulse.

Structure
REQ-032 Package display_pkg SHALL hold the state enum and SCREEN_W, SCREEN_H, PIPE_W, PASS_LIMIT defaults.
REQ-033 Sub-modules clear_screen (clk, reset, enable, done, x, y) and pipe_drawer (clk, reset, enable, done, pipe_x, pipe_y, x, y) SHALL be used; pipe_drawer instantiated twice.

Verification
REQ-034 Reset low, release -> color=0, (0,0); after 307199 further cycles (639,479) with clear done high; next cycle PIPE1.
REQ-035 pipe1=(100,380) -> first pixel (100,380) color=1; done at (149,479) after 5000 cycles; next cycle PIPE2 at pipe2 origin.
REQ-036 pipe2=(200,200) -> 50x280=14000-cycle pass ending (249,479); state returns to PIPE1.
REQ-037 Run alternation until counter saturates at 1023 -> next pipe2 done goes to CLEAR at (0,0), color=0, counter 0.
REQ-038 Assert reset at pixel 2000 of pipe1 -> immediately CLEAR at (0,0), no done pulse; full clear follows.
REQ-039 pipe1_y=600 -> single row of 50 cycles at y=479, done at (pipe1_x+49,479).
